alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width; shift/rotate amount is op_b[$clog2(WIDTH)-1:0].
REQ-002 The block SHALL use one clock and a reset that is synchronous and active-low, with ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-low reset
- start  in  1  operation request (Start_ALU_operation from control unit)
- opcode  in  6  operation code, sampled with start
- op_a  in  WIDTH  first operand, sampled with start
- op_b  in  WIDTH  second operand / shift amount, sampled with start
- alu_busy  out  1  high while an accepted operation is in progress
- done  out  1  one-cycle completion pulse
- result  out  WIDTH  registered result, held until next done
- wr_en  out  1  one-cycle register write strobe, coincident with done
- flags  out  4  {Z,O,N,C} = [3]zero, [2]overflow, [1]negative, [0]carry; held between operations

Function
REQ-003 Opcodes SHALL be: ADD 0x0C, SUB 0x0D, LSR 0x0E, LSL 0x0F, RSR 0x10, RSL 0x11, MOV 0x12, MUL 0x13, DIV 0x14, MOD 0x15, AND 0x16, OR 0x17, XOR 0x18, NOT 0x19, CMP 0x1A, TST 0x1B, INC 0x1C, DEC 0x1D.
REQ-004 States SHALL be IDLE, EXEC, ITER, DONE; IDLE->EXEC (single-cycle op) or ITER (MUL/DIV/MOD, non-zero divisor) on start; EXEC->DONE; ITER->DONE after WIDTH iterations; DONE->IDLE.
REQ-005 start SHALL be sampled only in IDLE; start in any other state is ignored and not queued.
REQ-006 alu_busy SHALL be 1 in EXEC, ITER and DONE, 0 in IDLE.
REQ-007 done SHALL pulse exactly one cycle, in DONE; single-cycle op: done 2 cycles after the start-sampling edge; MUL/DIV/MOD: WIDTH+2 cycles.
REQ-008 result and flags SHALL update only on entry to DONE.
REQ-009 wr_en SHALL equal done except for CMP, TST and unknown opcodes, where wr_en stays 0.
REQ-010 ADD/INC: C = unsigned carry-out, O = signed overflow; SUB/CMP/DEC: C = borrow (1 when minuend < subtrahend unsigned), O = signed overflow; INC/DEC use op_a and constant 1.
REQ-011 LSL/LSR logical shifts, RSL/RSR rotates, by amount op_b[3:0] (WIDTH 16): C = last bit shifted/rotated out, C = 0 for amount 0; O = 0.
REQ-012 AND/OR/XOR/NOT(op_a)/MOV(result=op_b)/TST(op_a AND op_b): C = 0, O = 0.
REQ-013 MUL SHALL be unsigned shift-add, one bit per cycle; result = low WIDTH bits; O = 1 when upper WIDTH bits non-zero; C = 0.
REQ-014 DIV/MOD SHALL be unsigned restoring division, one bit per cycle; DIV result = quotient, MOD result = remainder; C = 0, O = 0.
REQ-015 Divide by zero SHALL take the EXEC path (2-cycle latency): DIV result all-ones, MOD result = op_a, O = 1, C = 0.
REQ-016 For every op: Z = (result == 0), N = result[WIDTH-1]; CMP/TST flags computed on the discarded result.
REQ-017 Unknown opcode SHALL take the EXEC path: result unchanged, flags unchanged, done pulses, wr_en = 0.

Reset
REQ-018 On rst = 0 at a rising clk edge: state IDLE, alu_busy 0, done 0, wr_en 0, result 0, flags 4'b0000, iteration counter and working registers 0.
REQ-019 Reset mid-operation SHALL abort it with no done/wr_en pulse; start is ignored while rst = 0.

Configuration
REQ-020 Macro ALU_MULDIV_EN defined: MUL/DIV/MOD implemented per REQ-013..015.
REQ-021 ALU_MULDIV_EN undefined: no iterative datapath or ITER state; MUL/DIV/MOD treated as unknown opcodes per REQ-017.

Verification
REQ-022 ADD op_a=0x7FFF, op_b=0x0001 -> result 0x8000, flags Z0 O1 N1 C0, done 2 cycles after start.
REQ-023 CMP op_a=0x0003, op_b=0x0005 -> flags Z0 O0 N1 C1, wr_en stays 0, result unchanged.
REQ-024 MUL op_a=0x0100, op_b=0x0100 -> result 0x0000, Z1 O1, done at cycle 18, alu_busy high cycles 1..17.
REQ-025 DIV 0x0064/0x0007 -> 0x000E; MOD same -> 0x0002; DIV 0x1234/0x0000 -> 0xFFFF, O1, 2-cycle latency.
REQ-026 RSL op_a=0x8001, op_b=0x0001 -> result 0x0003, C1; start re-asserted while busy ignored; rst=0 mid-MUL -> no done, all outputs 0 next cycle.

Source files
------------

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU sequencer: single-cycle operations run through EXEC.
// Define ALU_MULDIV_EN to add the shift-add multiplier and restoring divider (ITER state).
module alu_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       opcode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             alu_busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             wr_en,
  output logic [3:0]       flags
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [5:0] OP_ADD = 6'h0C, OP_SUB = 6'h0D, OP_LSR = 6'h0E, OP_LSL = 6'h0F;
  localparam logic [5:0] OP_RSR = 6'h10, OP_RSL = 6'h11, OP_MOV = 6'h12;
  localparam logic [5:0] OP_AND = 6'h16, OP_OR  = 6'h17, OP_XOR = 6'h18, OP_NOT = 6'h19;
  localparam logic [5:0] OP_CMP = 6'h1A, OP_TST = 6'h1B, OP_INC = 6'h1C, OP_DEC = 6'h1D;

`ifdef ALU_MULDIV_EN
  localparam logic [5:0] OP_MUL = 6'h13, OP_DIV = 6'h14, OP_MOD = 6'h15;
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_ITER = 2'd2, S_DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_DONE = 2'd3} state_t;
`endif

  state_t           r_state, w_next;
  logic [5:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b, r_result;
  logic [3:0]       r_flags;
  logic             r_busy, r_done, r_wr_en;

  logic             w_enter_done;
  logic [WIDTH-1:0] w_bb, w_res, w_rot_r, w_rot_l;
  logic             w_c, w_o, w_known, w_write, w_add_o, w_sub_o;
  logic [WIDTH:0]   w_add, w_sub, w_lsl, w_lsr;
  logic [SHW-1:0]   w_sh;
  logic [3:0]       w_flags;

  // Rotate right by s; relies on WIDTH being a power of two so the index wraps.
  function automatic logic [WIDTH-1:0] rot_r(input logic [WIDTH-1:0] a, input logic [SHW-1:0] s);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = a[SHW'(i) + s];
    return r;
  endfunction

  assign w_bb    = ((r_op == OP_INC) || (r_op == OP_DEC)) ? {{(WIDTH-1){1'b0}}, 1'b1} : r_b;
  assign w_add   = {1'b0, r_a} + {1'b0, w_bb};
  assign w_sub   = {1'b0, r_a} - {1'b0, w_bb};
  assign w_add_o = (r_a[WIDTH-1] == w_bb[WIDTH-1]) && (w_add[WIDTH-1] != r_a[WIDTH-1]);
  assign w_sub_o = (r_a[WIDTH-1] != w_bb[WIDTH-1]) && (w_sub[WIDTH-1] != r_a[WIDTH-1]);
  assign w_sh    = r_b[SHW-1:0];
  // Extra bit on each shift catches the last bit pushed out (zero for amount 0).
  assign w_lsl   = {1'b0, r_a} << w_sh;
  assign w_lsr   = {r_a, 1'b0} >> w_sh;
  assign w_rot_r = rot_r(r_a, w_sh);
  assign w_rot_l = rot_r(r_a, {SHW{1'b0}} - w_sh);
  assign w_flags = {(w_res == {WIDTH{1'b0}}), w_o, w_res[WIDTH-1], w_c};
  assign w_enter_done = (w_next == S_DONE);

`ifdef ALU_MULDIV_EN
  logic [SHW:0]     r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo, w_rem_sub;
  logic [WIDTH:0]   w_mul_sum, w_rem_sh;
  logic             w_go_iter, w_rem_ge;

  assign w_go_iter = (opcode == OP_MUL) ||
                     (((opcode == OP_DIV) || (opcode == OP_MOD)) && (op_b != {WIDTH{1'b0}}));
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
  assign w_rem_sh  = {r_hi, r_lo[WIDTH-1]};
  assign w_rem_ge  = (w_rem_sh >= {1'b0, r_b});
  assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_b;

  // Iterative datapath: {r_hi,r_lo} is product for MUL, {remainder,quotient} for DIV/MOD.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= {(SHW+1){1'b0}};
      r_hi  <= {WIDTH{1'b0}};
      r_lo  <= {WIDTH{1'b0}};
    end else if ((r_state == S_IDLE) && start) begin
      r_cnt <= {(SHW+1){1'b0}};
      r_hi  <= {WIDTH{1'b0}};
      r_lo  <= (opcode == OP_MUL) ? op_b : op_a;
    end else if ((r_state == S_ITER) && (r_cnt != CNT_LAST)) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_op == OP_MUL) begin
        r_hi <= w_mul_sum[WIDTH:1];
        r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
      end else if (w_rem_ge) begin
        r_hi <= w_rem_sub;
        r_lo <= {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        r_hi <= w_rem_sh[WIDTH-1:0];
        r_lo <= {r_lo[WIDTH-2:0], 1'b0};
      end
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
`ifdef ALU_MULDIV_EN
          if (w_go_iter) w_next = S_ITER;
          else           w_next = S_EXEC;
`else
          w_next = S_EXEC;
`endif
        end else begin
          w_next = S_IDLE;
        end
      end
      S_EXEC: w_next = S_DONE;
`ifdef ALU_MULDIV_EN
      S_ITER: begin
        if (r_cnt == CNT_LAST) w_next = S_DONE;
        else                   w_next = S_ITER;
      end
`endif
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Result and flag selection for the latched operation.
  always_comb begin
    w_res   = r_result;
    w_c     = 1'b0;
    w_o     = 1'b0;
    w_known = 1'b1;
    w_write = 1'b1;
    case (r_op)
      OP_ADD, OP_INC: begin w_res = w_add[WIDTH-1:0]; w_c = w_add[WIDTH]; w_o = w_add_o; end
      OP_SUB, OP_DEC: begin w_res = w_sub[WIDTH-1:0]; w_c = w_sub[WIDTH]; w_o = w_sub_o; end
      OP_CMP: begin w_res = w_sub[WIDTH-1:0]; w_c = w_sub[WIDTH]; w_o = w_sub_o; w_write = 1'b0; end
      OP_LSL: begin w_res = w_lsl[WIDTH-1:0]; w_c = w_lsl[WIDTH]; end
      OP_LSR: begin w_res = w_lsr[WIDTH:1];   w_c = w_lsr[0]; end
      OP_RSL: begin
        w_res = w_rot_l;
        if (w_sh != {SHW{1'b0}}) w_c = w_rot_l[0];
        else                     w_c = 1'b0;
      end
      OP_RSR: begin
        w_res = w_rot_r;
        if (w_sh != {SHW{1'b0}}) w_c = w_rot_r[WIDTH-1];
        else                     w_c = 1'b0;
      end
      OP_MOV: w_res = r_b;
      OP_AND: w_res = r_a & r_b;
      OP_OR:  w_res = r_a | r_b;
      OP_XOR: w_res = r_a ^ r_b;
      OP_NOT: w_res = ~r_a;
      OP_TST: begin w_res = r_a & r_b; w_write = 1'b0; end
`ifdef ALU_MULDIV_EN
      OP_MUL: begin w_res = r_lo; w_o = (r_hi != {WIDTH{1'b0}}); end
      OP_DIV: begin
        if (r_b == {WIDTH{1'b0}}) begin w_res = {WIDTH{1'b1}}; w_o = 1'b1; end
        else                      begin w_res = r_lo; end
      end
      OP_MOD: begin
        if (r_b == {WIDTH{1'b0}}) begin w_res = r_a; w_o = 1'b1; end
        else                      begin w_res = r_hi; end
      end
`endif
      default: begin w_known = 1'b0; w_write = 1'b0; end
    endcase
  end

  // Operand capture and registered outputs; result/flags change only on entry to DONE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_op     <= 6'h00;
      r_a      <= {WIDTH{1'b0}};
      r_b      <= {WIDTH{1'b0}};
      r_result <= {WIDTH{1'b0}};
      r_flags  <= 4'b0000;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_wr_en  <= 1'b0;
    end else begin
      r_busy  <= (w_next != S_IDLE);
      r_done  <= w_enter_done;
      r_wr_en <= w_enter_done && w_write;
      if ((r_state == S_IDLE) && start) begin
        r_op <= opcode;
        r_a  <= op_a;
        r_b  <= op_b;
      end
      if (w_enter_done && w_write) r_result <= w_res;
      if (w_enter_done && w_known) r_flags  <= w_flags;
    end
  end

  assign alu_busy = r_busy;
  assign done     = r_done;
  assign result   = r_result;
  assign wr_en    = r_wr_en;
  assign flags    = r_flags;
endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: a behavioural model predicts each operation,
// a negedge monitor pops and compares whenever done pulses.
module tb_alu_sequencer;
  localparam int W = 16;
  localparam logic [5:0] OP_ADD = 6'h0C, OP_SUB = 6'h0D, OP_LSR = 6'h0E, OP_LSL = 6'h0F;
  localparam logic [5:0] OP_RSR = 6'h10, OP_RSL = 6'h11, OP_MOV = 6'h12, OP_MUL = 6'h13;
  localparam logic [5:0] OP_DIV = 6'h14, OP_MOD = 6'h15, OP_AND = 6'h16, OP_OR  = 6'h17;
  localparam logic [5:0] OP_XOR = 6'h18, OP_NOT = 6'h19, OP_CMP = 6'h1A, OP_TST = 6'h1B;
  localparam logic [5:0] OP_INC = 6'h1C, OP_DEC = 6'h1D;

  logic         clk = 1'b0;
  logic         rst, start, alu_busy, done, wr_en;
  logic [5:0]   opcode;
  logic [W-1:0] op_a, op_b, result;
  logic [3:0]   flags;

  typedef struct {
    logic [5:0]  op;
    logic [15:0] res;
    logic [3:0]  flg;
    logic        wr;
    int          lat;
    int          t0;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] m_res;
  logic [3:0]  m_flg;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [5:0]  ops [18] = '{OP_ADD, OP_SUB, OP_LSR, OP_LSL, OP_RSR, OP_RSL, OP_MOV, OP_MUL, OP_DIV,
                            OP_MOD, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_CMP, OP_TST, OP_INC, OP_DEC};

  alu_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .op_a(op_a), .op_b(op_b),
    .alu_busy(alu_busy), .done(done), .result(result), .wr_en(wr_en), .flags(flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: architectural result/flags updated from the operation's definition.
  task automatic predict(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    int unsigned ua, ub, p;
    int          sa, sb, sr, sh;
    logic [15:0] r, t;
    logic        c, o, known;
    ua = a; ub = b; sa = int'($signed(a)); sb = int'($signed(b));
    r = m_res; t = a; c = 1'b0; o = 1'b0; known = 1'b1;
    sh = int'(b[3:0]);
    e.wr = 1'b1; e.lat = 2;
    if (op == OP_INC || op == OP_DEC) begin ub = 1; sb = 1; end
    case (op)
      OP_ADD, OP_INC: begin
        p = ua + ub; r = p[15:0]; c = (p > 32'hFFFF);
        sr = sa + sb; o = (sr > 32767) || (sr < -32768);
      end
      OP_SUB, OP_DEC, OP_CMP: begin
        r = 16'(ua - ub); c = (ua < ub);
        sr = sa - sb; o = (sr > 32767) || (sr < -32768);
        if (op == OP_CMP) e.wr = 1'b0;
      end
      OP_LSL: begin for (int i = 0; i < sh; i++) begin c = t[15]; t = {t[14:0], 1'b0}; end r = t; end
      OP_LSR: begin for (int i = 0; i < sh; i++) begin c = t[0]; t = {1'b0, t[15:1]}; end r = t; end
      OP_RSL: begin for (int i = 0; i < sh; i++) begin c = t[15]; t = {t[14:0], t[15]}; end r = t; end
      OP_RSR: begin for (int i = 0; i < sh; i++) begin c = t[0]; t = {t[0], t[15:1]}; end r = t; end
      OP_MOV: r = b;
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOT: r = ~a;
      OP_TST: begin r = a & b; e.wr = 1'b0; end
`ifdef ALU_MULDIV_EN
      OP_MUL: begin p = ua * ub; r = p[15:0]; o = (p[31:16] != 16'h0); e.lat = W + 2; end
      OP_DIV: begin
        if (ub == 0) begin r = 16'hFFFF; o = 1'b1; end
        else begin r = 16'(ua / ub); e.lat = W + 2; end
      end
      OP_MOD: begin
        if (ub == 0) begin r = a; o = 1'b1; end
        else begin r = 16'(ua % ub); e.lat = W + 2; end
      end
`endif
      default: begin known = 1'b0; e.wr = 1'b0; end
    endcase
    if (known) begin
      m_flg = {(r == 16'h0), o, r[15], c};
      if (e.wr) m_res = r;
    end
    e.op = op; e.res = m_res; e.flg = m_flg; e.t0 = cyc;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (alu_busy !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    if (alu_busy !== 1'b0) begin
      checks++; errors++;
      $display("FAIL idle_timeout: alu_busy %0b after %0d cycles, required 0", alu_busy, n);
    end
  endtask

  // Issue one operation from IDLE; optionally re-assert start while busy (must be ignored).
  task automatic issue(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b, input bit poke);
    wait_idle();
    start = 1'b1; opcode = op; op_a = a; op_b = b;
    predict(op, a, b);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", alu_busy, 1'b1);
    if (poke) begin
      start = 1'b1; opcode = ops[$urandom_range(0, 17)]; op_a = 16'($urandom); op_b = 16'($urandom);
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Monitor: compare every done pulse against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_done_queue_size", exp_q.size(), 0);
        end else begin
          mon_e = exp_q.pop_front();
          check($sformatf("result op%0h", mon_e.op), result, mon_e.res);
          check($sformatf("flags op%0h", mon_e.op), flags, mon_e.flg);
          check($sformatf("wr_en op%0h", mon_e.op), wr_en, mon_e.wr);
          check($sformatf("latency op%0h", mon_e.op), cyc - mon_e.t0, mon_e.lat);
        end
      end else begin
        check("wr_en_without_done", wr_en, 1'b0);
      end
    end
  end

  initial begin
    int bad;
    rst = 1'b0; start = 1'b0; opcode = 6'h00; op_a = 16'h0; op_b = 16'h0;
    m_res = 16'h0; m_flg = 4'b0000;
    repeat (3) @(negedge clk);
    check("reset_busy", alu_busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_wr_en", wr_en, 1'b0);
    check("reset_result", result, 16'h0);
    check("reset_flags", flags, 4'b0000);
    rst = 1'b1;
    @(negedge clk);

    issue(OP_ADD, 16'h7FFF, 16'h0001, 1'b0); wait_idle();
    check("add_ovf_result", result, 16'h8000);
    check("add_ovf_flags", flags, 4'b0110);
    issue(OP_CMP, 16'h0003, 16'h0005, 1'b1); wait_idle();
    check("cmp_result_held", result, 16'h8000);
    check("cmp_flags", flags, 4'b0011);
    issue(OP_RSL, 16'h8001, 16'h0001, 1'b1); wait_idle();
    check("rsl_result", result, 16'h0003);
    check("rsl_flags", flags, 4'b0001);
    issue(6'h3F, 16'h1111, 16'h2222, 1'b0); wait_idle();
    check("unknown_result_held", result, 16'h0003);
    check("unknown_flags_held", flags, 4'b0001);
`ifdef ALU_MULDIV_EN
    issue(OP_MUL, 16'h0100, 16'h0100, 1'b0);
    bad = 0;
    for (int i = 2; i <= 17; i++) begin
      @(negedge clk);
      if (alu_busy !== 1'b1 || done !== 1'b0) bad++;
    end
    check("mul_busy_window_bad_cycles", bad, 0);
    wait_idle();
    check("mul_result", result, 16'h0000);
    check("mul_flags", flags, 4'b1100);
    issue(OP_DIV, 16'h0064, 16'h0007, 1'b1); wait_idle();
    check("div_result", result, 16'h000E);
    issue(OP_MOD, 16'h0064, 16'h0007, 1'b0); wait_idle();
    check("mod_result", result, 16'h0002);
    issue(OP_DIV, 16'h1234, 16'h0000, 1'b0); wait_idle();
    check("div0_result", result, 16'hFFFF);
    check("div0_flags", flags, 4'b0110);
`else
    issue(OP_MUL, 16'h0100, 16'h0100, 1'b0); wait_idle();
    check("mul_disabled_result_held", result, 16'h0003);
`endif

    // Reset in the middle of an operation: no done, everything cleared, start ignored.
    issue(OP_MUL, 16'h1234, 16'h5678, 1'b0);
    void'(exp_q.pop_back());
    m_res = 16'h0; m_flg = 4'b0000;
    rst = 1'b0; start = 1'b1; opcode = OP_ADD; op_a = 16'h0001; op_b = 16'h0001;
    @(negedge clk);
    check("abort_busy", alu_busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_wr_en", wr_en, 1'b0);
    check("abort_result", result, 16'h0);
    check("abort_flags", flags, 4'b0000);
    @(negedge clk);
    start = 1'b0; rst = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_still_idle", alu_busy, 1'b0);

    for (int n = 0; n < 300; n++) begin
      logic [5:0] op;
      logic [15:0] a, b;
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 17)];
      a = pick();
      b = ($urandom_range(0, 7) == 0) ? 16'h0000 : pick();
      issue(op, a, b, ($urandom_range(0, 3) == 0));
    end
    wait_idle();
    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
